// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner
// encoding and the all-ones byte-enable mask used by reads.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_WAIT
   } arb_state_e;

   typedef enum logic {
      OWNER_IF,
      OWNER_DM
   } arb_owner_e;

   localparam int                    BE_MAX_W    = 16;
   localparam logic [BE_MAX_W-1:0]   BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch/data) and memory-side signals of the arbiter, bundled with
// a slave view for the arbiter and a master view for whoever drives it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_done_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic [BE_W-1:0]   dm_be_i;
   logic              dm_done_o;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              stall_f_o;
   logic              stall_m_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [BE_W-1:0]   mem_be_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
      output stall_f_o, stall_m_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
      input  stall_f_o, stall_m_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Fixed data-over-fetch priority pick with a saturating starvation counter
// that hands the slot to fetch after STARVE_MAX consecutive data wins.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic arb_i,
   input  logic if_req_i,
   input  logic dm_req_i,
   output logic grant_if_o,
   output logic grant_dm_o
);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_starved;

   assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_MAX));
   assign grant_if_o = arb_i && if_req_i && (!dm_req_i || w_starved);
   assign grant_dm_o = arb_i && dm_req_i && !grant_if_o;

   // Counter only moves on arbitration cycles; a fetch win or an idle fetch clears it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_starve_cnt <= '0;
      end else if (arb_i) begin
         if (grant_if_o || !if_req_i) begin
            r_starve_cnt <= '0;
         end else if (grant_dm_o && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data access, one
// transaction at a time, with combinational done/stall back to the pipeline.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   mem_port_arbiter_if.slave   bus
);

   localparam int BE_W = DATA_W / 8;

   arb_state_e          r_state;
   arb_owner_e          r_owner;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [BE_W-1:0]     r_mem_be;

   logic                w_arb;
   logic                w_grant_if;
   logic                w_grant_dm;
   logic                w_complete;
   logic [BE_W-1:0]     w_be_ones;

   assign w_arb     = (r_state == ARB_IDLE);
   assign w_be_ones = BE_ALL_ONES[BE_W-1:0];

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .arb_i      (w_arb),
      .if_req_i   (bus.if_req_i),
      .dm_req_i   (bus.dm_req_i),
      .grant_if_o (w_grant_if),
      .grant_dm_o (w_grant_dm)
   );

   // A grant accompanied by rvalid completes straight out of REQ.
   assign w_complete = ((r_state == ARB_REQ) && bus.mem_gnt_i && bus.mem_rvalid_i) ||
                       ((r_state == ARB_WAIT) && bus.mem_rvalid_i);

   assign bus.if_done_o  = w_complete && (r_owner == OWNER_IF);
   assign bus.dm_done_o  = w_complete && (r_owner == OWNER_DM);
   assign bus.if_rdata_o = bus.mem_rdata_i;
   assign bus.dm_rdata_o = bus.mem_rdata_i;
   assign bus.stall_f_o  = bus.if_req_i && !bus.if_done_o;
   assign bus.stall_m_o  = bus.dm_req_i && !bus.dm_done_o;

   assign bus.mem_req_o   = r_mem_req;
   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;
   assign bus.mem_be_o    = r_mem_be;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ARB_IDLE;
         r_owner     <= OWNER_DM;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         unique case (r_state)
            ARB_IDLE: begin
               if (w_grant_dm) begin
                  r_state     <= ARB_REQ;
                  r_owner     <= OWNER_DM;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= bus.dm_we_i;
                  r_mem_addr  <= bus.dm_addr_i;
                  r_mem_wdata <= bus.dm_wdata_i;
                  r_mem_be    <= bus.dm_we_i ? bus.dm_be_i : w_be_ones;
               end else if (w_grant_if) begin
                  r_state     <= ARB_REQ;
                  r_owner     <= OWNER_IF;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= bus.if_addr_i;
                  r_mem_wdata <= '0;
                  r_mem_be    <= w_be_ones;
               end
            end
            ARB_REQ: begin
               if (bus.mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= bus.mem_rvalid_i ? ARB_IDLE : ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (bus.mem_rvalid_i) begin
                  r_state <= ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory issues are queued when
// requests are driven and checked at each grant and done pulse.
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic        is_if;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t       exp_q[$];
   logic [1:0] own_q[$];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4),
      .CNT_W      (3)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_if, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
      txn_t t;
      t.is_if = is_if; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
      exp_q.push_back(t);
   endtask

   // One clock: drive memory side, check outputs mid-cycle, then advance.
   task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                       input logic e_mreq, input logic e_sf, input logic e_sm,
                       input string tag);
      txn_t       e;
      logic [1:0] o;
      bus.mem_gnt_i    = g;
      bus.mem_rvalid_i = rv;
      bus.mem_rdata_i  = rd;
      #1;
      chk({tag, "_mem_req"}, bus.mem_req_o, e_mreq);
      chk({tag, "_stall_f"}, bus.stall_f_o, e_sf);
      chk({tag, "_stall_m"}, bus.stall_m_o, e_sm);
      if (bus.mem_req_o && g) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_issue"}, bus.mem_req_o, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, bus.mem_addr_o, e.addr);
            chk({tag, "_we"}, bus.mem_we_o, e.we);
            chk({tag, "_be"}, bus.mem_be_o, e.be);
            if (e.we) chk({tag, "_wdata"}, bus.mem_wdata_o, e.wdata);
            own_q.push_back({e.is_if, e.we});
         end
      end
      if (bus.if_done_o || bus.dm_done_o) begin
         if (own_q.size() == 0) begin
            chk({tag, "_spurious_done"}, {bus.if_done_o, bus.dm_done_o}, 2'b00);
         end else begin
            o = own_q.pop_front();
            chk({tag, "_done_owner"}, {bus.if_done_o, bus.dm_done_o}, o[1] ? 2'b10 : 2'b01);
            if (o[1]) chk({tag, "_if_rdata"}, bus.if_rdata_o, rd);
            else if (!o[0]) chk({tag, "_dm_rdata"}, bus.dm_rdata_o, rd);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
      chk({tag, "_mem_we"}, bus.mem_we_o, 1'b0);
      chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'h0);
      chk({tag, "_mem_be"}, bus.mem_be_o, 4'h0);
      chk({tag, "_dones"}, {bus.if_done_o, bus.dm_done_o}, 2'b00);
      chk({tag, "_stalls"}, {bus.stall_f_o, bus.stall_m_o}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
      bus.dm_req_i = 1'b0;  bus.dm_we_i = 1'b0;  bus.dm_addr_i = '0;
      bus.dm_wdata_i = '0;  bus.dm_be_i = '0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      #1;
      chk_idle_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Lone fetch, zero wait states.
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
      push(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      step(0, 0, 32'h0,        0, 1, 0, "f1_c0");
      step(1, 1, 32'hCAFE0001, 1, 0, 0, "f1_c1");
      bus.if_req_i = 1'b0;
      step(0, 0, 32'h0,        0, 0, 0, "f1_c2");

      // Simultaneous fetch and store: store goes first.
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h1000;
      bus.dm_wdata_i = 32'hDEADBEEF; bus.dm_be_i = 4'h3;
      push(1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'h3);
      push(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
      step(0, 0, 32'h0,        0, 1, 1, "both_c0");
      step(1, 1, 32'h11111111, 1, 1, 0, "both_c1");
      bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
      step(0, 0, 32'h0,        0, 1, 0, "both_c2");
      step(1, 1, 32'h22222222, 1, 0, 0, "both_c3");
      bus.if_req_i = 1'b0;
      step(0, 0, 32'h0,        0, 0, 0, "both_c4");

      // Starvation guard: both held, expect dm x4 then if, twice.
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h2000; bus.dm_be_i = 4'h1;
      for (int t = 0; t < 10; t++) begin
         if ((t % 5) == 4) push(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
         else              push(1'b0, 1'b0, 32'h2000, 32'h0, 4'hF);
      end
      for (int t = 0; t < 10; t++) begin
         logic own_if;
         own_if = ((t % 5) == 4);
         step(0, 0, 32'h0, 0, 1, 1, "stv_idle");
         step(1, 1, 32'h3000 + t, 1, !own_if, own_if, "stv_req");
      end
      bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
      step(0, 0, 32'h0, 0, 0, 0, "stv_end");

      // Wait states: gnt on third REQ cycle, rvalid two cycles later.
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h3000;
      push(1'b0, 1'b0, 32'h3000, 32'h0, 4'hF);
      step(0, 0, 32'h0, 0, 0, 1, "ws_c0");
      chk("ws_c1_addr", bus.mem_addr_o, 32'h3000);
      step(0, 1, 32'hBAD0BAD0, 1, 0, 1, "ws_c1");
      chk("ws_c2_addr", bus.mem_addr_o, 32'h3000);
      chk("ws_c2_be", bus.mem_be_o, 4'hF);
      step(0, 0, 32'h0, 1, 0, 1, "ws_c2");
      step(1, 0, 32'h0, 1, 0, 1, "ws_c3");
      step(1, 0, 32'h0, 0, 0, 1, "ws_c4");
      step(0, 1, 32'h55555555, 0, 0, 0, "ws_c5");
      bus.dm_req_i = 1'b0;
      step(0, 0, 32'h0, 0, 0, 0, "ws_c6");

      // Reset during WAIT, then a stray rvalid.
      bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h4000;
      push(1'b0, 1'b0, 32'h4000, 32'h0, 4'hF);
      step(0, 0, 32'h0, 0, 0, 1, "rw_c0");
      step(1, 0, 32'h0, 1, 0, 1, "rw_c1");
      step(0, 0, 32'h0, 0, 0, 1, "rw_c2");
      rst_n = 1'b0;
      bus.dm_req_i = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk_idle_outputs("rw_reset");
      own_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 1, 32'h77777777, 0, 0, 0, "rw_stray");
      chk("rw_stray_after", {bus.if_done_o, bus.dm_done_o}, 2'b00);

      // Losing fetch redirects its address while data is serviced.
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h5000;
      push(1'b0, 1'b0, 32'h5000, 32'h0, 4'hF);
      push(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
      step(0, 0, 32'h0, 0, 1, 1, "rd_c0");
      bus.if_addr_i = 32'h400;
      step(0, 0, 32'h0, 1, 1, 1, "rd_c1");
      step(1, 1, 32'h66666666, 1, 1, 0, "rd_c2");
      bus.dm_req_i = 1'b0;
      step(0, 0, 32'h0, 0, 1, 0, "rd_c3");
      step(1, 1, 32'h88888888, 1, 0, 0, "rd_c4");
      bus.if_req_i = 1'b0;
      step(0, 0, 32'h0, 0, 0, 0, "rd_c5");

      chk("sb_issue_drain", exp_q.size(), 0);
      chk("sb_done_drain", own_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (FE) and data access (ME) in the pipelined core.
- Serializes requests: one outstanding memory transaction at a time.
- Data has priority, with a starvation guard for fetch.
- Drives per-requester stall outputs that the pipeline control combines with its load-use stall.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; BE_W = DATA_W/8 is derived locally
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; range 1..7
- CNT_W, 3, starvation counter width; must hold STARVE_MAX

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_done_o  out  1  fetch complete; rdata valid this cycle
- if_rdata_o  out  DATA_W  fetch data
- dm_req_i  in  1  data request; held until dm_done_o
- dm_we_i  in  1  1 = store
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_be_i  in  BE_W  store byte enables
- dm_done_o  out  1  data access complete
- dm_rdata_o  out  DATA_W  load data
- stall_f_o  out  1  freeze FE/DE latches
- stall_m_o  out  1  freeze EXE/ME/WB progress
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  BE_W  byte enables; all ones for reads
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  response valid; issued for reads and writes
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (async, rst_n_i low):
  - state = IDLE, owner = DM, starve_cnt = 0.
  - All mem_* registers = 0.
  - done outputs and stalls depend on state: they are 0 with no request pending.
  - Reset mid-transaction abandons it. A late mem_rvalid_i arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any req is high, arbitrate and latch owner, we, addr, wdata, be into the mem_* registers; go to REQ next cycle.
  - Fetch latches we = 0 and be = all ones.
- Arbitration:
  - dm wins if both request, unless starve_cnt == STARVE_MAX; then if wins.
  - starve_cnt increments when dm is granted while if_req_i is high.
  - starve_cnt clears when if is granted or if_req_i is low in IDLE.
  - starve_cnt saturates and never wraps.
- REQ:
  - mem_req_o = 1 with stable fields.
  - On mem_gnt_i: if mem_rvalid_i is also high, complete (see WAIT); else go to WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: owner's done_o = 1 combinationally, owner's rdata_o = mem_rdata_i; go to IDLE.
  - dm_done_o also pulses for stores; rdata is don't-care then.
- Done outputs:
  - Done asserts for exactly one cycle per transaction, only to the owner. The non-owner's done stays 0.
  - The requester may present a new request on the cycle after done. No duplicate issue occurs because IDLE is entered that cycle.
- Latency: minimum request-to-done is 2 cycles (IDLE, then REQ with gnt and rvalid together). Unbounded with memory wait states.
- Stalls (combinational): stall_f_o = if_req_i & ~if_done_o; stall_m_o = dm_req_i & ~dm_done_o.
- Request changes while not owner: the losing request may change address freely, e.g. on a branch redirect. Only latched fields are used.
- Owner dropping req mid-transaction is illegal; the transaction still completes and the done pulse is delivered regardless.
- mem_rvalid_i in IDLE or REQ without gnt is ignored. mem_gnt_i outside REQ is ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT}.
  - typedef enum arb_owner_e {OWNER_IF, OWNER_DM}.
  - localparam BE_ALL_ONES helper.
- One sub-module, mem_arb_pick: combinational priority pick plus the starvation counter register. Outputs grant_if and grant_dm; inputs are the requests and an arbitrate strobe from IDLE.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Lone fetch, addr 0x100, memory gnt+rvalid same cycle:
  - mem_req_o high on cycle 1 with addr 0x100 and be=0xF.
  - if_done_o on cycle 1 with rdata = mem_rdata_i.
  - stall_f_o high on cycle 0 only.
- Simultaneous if (0x200) and dm store (0x1000, wdata 0xDEADBEEF, be 0x3):
  - Store is issued first with we=1, be=0x3.
  - Fetch is issued after dm_done_o.
  - stall_f_o stays high through both transactions.
- Starvation: if_req_i held, dm_req_i re-asserted back-to-back, STARVE_MAX=4:
  - 4 dm grants, then 1 if grant.
  - Counter returns to 0; pattern repeats.
- Memory wait states: gnt after 3 cycles, rvalid 2 cycles later:
  - mem_* fields stable throughout REQ.
  - mem_req_o drops in WAIT.
  - Exactly one dm_done_o pulse; total 6 cycles.
- Reset asserted during WAIT, then rvalid pulsed after release:
  - Outputs return to 0 immediately.
  - State is IDLE.
  - Stray rvalid produces no done pulse.
- Fetch loses arbitration and changes addr 0x300→0x400 while dm is serviced:
  - Issued fetch address is 0x400.
